// File: rtl/pipeline_mdu_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Latency: none, wires only.
// Backpressure: the EX stage holds its request while busy is high.
//
// master: EX-stage side, drives start/flush/op/rs1/rs2/rd_in and reads the results.
// slave : MDU side, reads the request and drives busy/done/result/rd_out.
interface pipeline_mdu_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            flush;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic [4:0]      rd_in;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start, flush, op, rs1, rs2, rd_in,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, flush, op, rs1, rs2, rd_in,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/pipeline_mdu.sv
// Iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Latency: XLEN/MUL_BITS+1 cycles for multiplies, XLEN+1 for divides, 1 for div-by-zero/overflow.
// Backpressure: busy is high while iterating; start is ignored then, flush aborts without a done pulse.
//
// Ports: clk (rising edge), reset (async, active low), mdu (slave modport):
//   start/op/rs1/rs2/rd_in issue a request, flush kills the in-flight op,
//   busy marks CALC, done pulses for one cycle with result/rd_out (held until the next completion).
module pipeline_mdu #(
   parameter int XLEN     = 32,  // even, >= 8
   parameter int MUL_BITS = 1    // 1, 2 or 4; must divide XLEN
) (
   input  logic          clk,
   input  logic          reset,
   pipeline_mdu_if.slave mdu
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam int W2 = 2 * XLEN;
   localparam int WP = XLEN + MUL_BITS;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [2:0]      op_q;
   logic            neg_q;      // negate the final magnitude
   logic [XLEN-1:0] opnd;       // multiplicand magnitude, or divisor magnitude
   logic [W2-1:0]   acc;        // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
   logic [CW-1:0]   cnt;
   logic [4:0]      rd_q;
   logic            busy_q;
   logic            done_q;
   logic [XLEN-1:0] result_q;
   logic [4:0]      rd_out_q;

   assign mdu.busy   = busy_q;
   assign mdu.done   = done_q;
   assign mdu.result = result_q;
   assign mdu.rd_out = rd_out_q;

   // ---------------- accept-time decode ----------------
   logic            signed_a, signed_b;
   logic            sgn_a, sgn_b;
   logic            is_div, div_zero, div_ovf, accept;
   logic [XLEN-1:0] mag_a, mag_b, fast_res;

   always_comb begin
      signed_a = 1'b0;
      signed_b = 1'b0;
      unique case (mdu.op)
         3'b000, 3'b001, 3'b100, 3'b110: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         3'b010: signed_a = 1'b1;
         default: ;
      endcase
      sgn_a    = signed_a & mdu.rs1[XLEN-1];
      sgn_b    = signed_b & mdu.rs2[XLEN-1];
      mag_a    = sgn_a ? -mdu.rs1 : mdu.rs1;
      mag_b    = sgn_b ? -mdu.rs2 : mdu.rs2;
      is_div   = mdu.op[2];
      div_zero = is_div & (mdu.rs2 == {XLEN{1'b0}});
      div_ovf  = is_div & ~mdu.op[0]
               & (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}})
               & (mdu.rs2 == {XLEN{1'b1}});
      // op[1] selects remainder for the divide group
      if (div_zero)
         fast_res = mdu.op[1] ? mdu.rs1 : {XLEN{1'b1}};
      else
         fast_res = mdu.op[1] ? {XLEN{1'b0}} : mdu.rs1;
      accept   = mdu.start & ~mdu.flush & (state != CALC);
   end

   // ---------------- one iteration step ----------------
   logic [WP-1:0]   partial, psum;
   logic [XLEN:0]   shl, trial;
   logic [W2-1:0]   acc_nxt, full;
   logic [XLEN-1:0] mag_res, calc_res;

   always_comb begin
      // shift-add: add opnd * next multiplier digit into the high half, shift right
      partial = WP'(opnd) * WP'(acc[MUL_BITS-1:0]);
      psum    = WP'(acc[W2-1:XLEN]) + partial;
      // restoring divide: shift in the next dividend bit, subtract if it fits
      shl     = {acc[W2-1:XLEN], acc[XLEN-1]};
      trial   = shl - {1'b0, opnd};
      if (op_q[2]) begin
         if (!trial[XLEN])
            acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
         else
            acc_nxt = {shl[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = {psum, acc[XLEN-1:MUL_BITS]};
      end

      // final result is formed from the value the last step produces
      full    = neg_q ? -acc_nxt : acc_nxt;
      mag_res = op_q[1] ? acc_nxt[W2-1:XLEN] : acc_nxt[XLEN-1:0];
      if (op_q[2])
         calc_res = neg_q ? -mag_res : mag_res;
      else if (op_q[1:0] == 2'b00)
         calc_res = full[XLEN-1:0];
      else
         calc_res = full[W2-1:XLEN];
   end

   // ---------------- control / state ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         op_q     <= 3'b000;
         neg_q    <= 1'b0;
         opnd     <= '0;
         acc      <= '0;
         cnt      <= '0;
         rd_q     <= 5'd0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         rd_out_q <= 5'd0;
      end else if (mdu.flush && state != IDLE) begin
         // abort; result/rd_out keep the last completed values
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (accept) begin
         op_q  <= mdu.op;
         rd_q  <= mdu.rd_in;
         // remainder takes the dividend sign, everything else the sign product
         neg_q <= (mdu.op[2] & mdu.op[1]) ? sgn_a : (sgn_a ^ sgn_b);
         opnd  <= is_div ? mag_b : mag_a;
         acc   <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
         if (div_zero || div_ovf) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= fast_res;
            rd_out_q <= mdu.rd_in;
         end else begin
            state  <= CALC;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            cnt    <= is_div ? CW'(XLEN) : CW'(XLEN / MUL_BITS);
         end
      end else if (state == CALC) begin
         acc <= acc_nxt;
         cnt <= cnt - CW'(1);
         if (cnt == CW'(1)) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= calc_res;
            rd_out_q <= rd_q;
         end
      end else begin
         state  <= IDLE;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipeline_mdu.sv
// Bench for pipeline_mdu: a radix-1 and a radix-4 instance checked against a
// vector table through an expected-result queue, plus flush, reset and
// back-to-back sequences.
module tb_pipeline_mdu;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic [4:0]  rd;
      bit          fast;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   localparam int NV = 23;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;
   exp_t q1[$];
   exp_t q4[$];
   logic [31:0] last_res1;
   logic [4:0]  last_rd1;
   vec_t tbl [NV];

   pipeline_mdu_if #(.XLEN(32)) m1 ();
   pipeline_mdu_if #(.XLEN(32)) m4 ();

   pipeline_mdu #(.XLEN(32), .MUL_BITS(1)) u1 (.clk(clk), .reset(reset), .mdu(m1));
   pipeline_mdu #(.XLEN(32), .MUL_BITS(4)) u4 (.clk(clk), .reset(reset), .mdu(m4));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q1.size() : q4.size();
   endfunction

   function automatic logic busy_of(input int d);
      return (d == 0) ? m1.busy : m4.busy;
   endfunction

   task automatic drive(input int d, input logic s, input logic f, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      if (d == 0) begin
         m1.start = s; m1.flush = f; m1.op = op; m1.rs1 = a; m1.rs2 = b; m1.rd_in = rd;
      end else begin
         m4.start = s; m4.flush = f; m4.op = op; m4.rs1 = a; m4.rs2 = b; m4.rd_in = rd;
      end
   endtask

   // completion monitor: every done pulse must match the oldest expectation
   task automatic mon(input int d, input logic [31:0] r, input logic [4:0] rd);
      exp_t e;
      if (qsize(d) == 0) begin
         tests++;
         fails++;
         $display("FAIL unexpected_done dut%0d: got result %h rd %0d, none outstanding", d, r, rd);
      end else begin
         if (d == 0) e = q1.pop_front();
         else        e = q4.pop_front();
         chk($sformatf("result dut%0d rd%0d", d, e.rd), r, e.res);
         chk($sformatf("rd_out dut%0d rd%0d", d, e.rd), {27'd0, rd}, {27'd0, e.rd});
         chk($sformatf("done_cycle dut%0d rd%0d", d, e.rd), cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (reset && m1.done) mon(0, m1.result, m1.rd_out);
      if (reset && m4.done) mon(1, m4.result, m4.rd_out);
   end

   // issue one operation, then wait for its completion counting busy cycles
   task automatic issue(input int d, input vec_t v, input int idx);
      exp_t e;
      int   n, nb, k;
      n = v.fast ? 0 : (v.op[2] ? 32 : ((d == 0) ? 32 : 8));
      drive(d, 1'b1, 1'b0, v.op, v.a, v.b, v.rd);
      e.res = v.exp;
      e.rd  = v.rd;
      e.cyc = cyc + 1 + n;
      if (d == 0) begin
         q1.push_back(e);
         last_res1 = v.exp;
         last_rd1  = v.rd;
      end else begin
         q4.push_back(e);
      end
      @(negedge clk); #1;
      drive(d, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      nb = 0;
      k  = 0;
      forever begin
         if (busy_of(d)) nb++;
         if (qsize(d) == 0 || k >= 100) break;
         @(negedge clk); #1;
         k++;
      end
      chk($sformatf("timeout dut%0d vec%0d", d, idx), qsize(d), 0);
      if (d == 0) q1.delete(); else q4.delete();
      chk($sformatf("busy_cycles dut%0d vec%0d", d, idx), nb, n);
   endtask

   initial begin
      int   k, k0, ndone;
      exp_t e;

      //            op      rs1           rs2           expected      rd     fast
      tbl[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 5'd3,  1'b0};
      tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 5'd4,  1'b0};
      tbl[2]  = '{3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 5'd5,  1'b0};
      tbl[3]  = '{3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 5'd6,  1'b0};
      tbl[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 5'd7,  1'b0};
      tbl[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 5'd8,  1'b0};
      tbl[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       5'd9,  1'b0};
      tbl[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        5'd10, 1'b0};
      tbl[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 5'd11, 1'b1};
      tbl[9]  = '{3'b110, 32'd5,        32'd0,        32'd5,        5'd12, 1'b1};
      tbl[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd13, 1'b1};
      tbl[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'd14, 1'b1};
      tbl[12] = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 5'd15, 1'b0};
      tbl[13] = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 5'd16, 1'b0};
      tbl[14] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'd17, 1'b0};
      tbl[15] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd18, 1'b0};
      tbl[16] = '{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, 5'd19, 1'b0};
      tbl[17] = '{3'b110, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd20, 1'b0};
      tbl[18] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 5'd21, 1'b0};
      tbl[19] = '{3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'd22, 1'b0};
      tbl[20] = '{3'b100, 32'd0,        32'd0,        32'hFFFFFFFF, 5'd23, 1'b1};
      tbl[21] = '{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 5'd24, 1'b0};
      tbl[22] = '{3'b100, 32'h80000000, 32'h00000001, 32'h80000000, 5'd25, 1'b0};

      tests = 0;
      fails = 0;
      last_res1 = '0;
      last_rd1  = '0;
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      repeat (3) @(negedge clk);
      #1;
      chk("reset busy dut0",   {31'd0, m1.busy}, 32'd0);
      chk("reset done dut0",   {31'd0, m1.done}, 32'd0);
      chk("reset result dut0", m1.result, 32'd0);
      chk("reset rd_out dut0", {27'd0, m1.rd_out}, 32'd0);
      chk("reset busy dut1",   {31'd0, m4.busy}, 32'd0);
      chk("reset result dut1", m4.result, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk); #1;

      for (int d = 0; d < 2; d++)
         for (int i = 0; i < NV; i++)
            issue(d, tbl[i], i);

      // result is held while idle
      repeat (3) @(negedge clk);
      #1;
      chk("held result dut0", m1.result, last_res1);

      // flush at CALC cycle 10 with a simultaneous start
      drive(0, 1'b1, 1'b0, 3'b000, 32'd3, 32'd4, 5'd9);
      @(negedge clk); #1;
      drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      repeat (9) begin
         @(negedge clk); #1;
      end
      chk("flush precondition busy", {31'd0, m1.busy}, 32'd1);
      drive(0, 1'b1, 1'b1, 3'b101, 32'd100, 32'd7, 5'd12);
      @(negedge clk); #1;
      drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      chk("flush busy",   {31'd0, m1.busy}, 32'd0);
      chk("flush done",   {31'd0, m1.done}, 32'd0);
      chk("flush result", m1.result, last_res1);
      chk("flush rd_out", {27'd0, m1.rd_out}, {27'd0, last_rd1});
      ndone = 0;
      repeat (40) begin
         @(negedge clk); #1;
         if (m1.done) ndone++;
      end
      chk("flush no done pulse", ndone, 0);

      // radix-4: start held through CALC is ignored, accepted again in DONE
      drive(1, 1'b1, 1'b0, 3'b000, 32'h12345678, 32'h00000010, 5'd5);
      k0 = cyc + 1;
      e.res = 32'h23456780; e.rd = 5'd5; e.cyc = k0 + 8;
      q4.push_back(e);
      e.res = 32'd15;       e.rd = 5'd6; e.cyc = k0 + 17;
      q4.push_back(e);
      @(negedge clk); #1;
      drive(1, 1'b1, 1'b0, 3'b000, 32'd3, 32'd5, 5'd6);
      k = 0;
      while (cyc < k0 + 9 && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      chk("b2b busy after reissue", {31'd0, m4.busy}, 32'd1);
      k = 0;
      while (q4.size() != 0 && k < 50) begin
         @(negedge clk); #1;
         k++;
      end
      chk("b2b timeout", q4.size(), 0);
      q4.delete();

      // asynchronous reset in the middle of CALC
      drive(0, 1'b1, 1'b0, 3'b000, 32'd3, 32'd4, 5'd9);
      @(negedge clk); #1;
      drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      repeat (5) begin
         @(negedge clk); #1;
      end
      chk("areset precondition busy", {31'd0, m1.busy}, 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("areset busy",   {31'd0, m1.busy}, 32'd0);
      chk("areset done",   {31'd0, m1.done}, 32'd0);
      chk("areset result", m1.result, 32'd0);
      chk("areset rd_out", {27'd0, m1.rd_out}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);
      #1;
      chk("post reset idle busy", {31'd0, m1.busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
